// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - UART command assembly and response transmit sequencing
//
// Builds 16-bit host commands from pairs of received UART bytes, high byte
// first, and drops a half-received command if the low byte is late. Response
// bytes from the command processor are forwarded to the UART transmitter
// through one active slot plus a one-deep pending slot.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_rdy/rx_data  receiver byte available (level) and its data
//   clr_rx_rdy      combinational consume strobe back to the receiver
//   cmd/cmd_rdy     assembled command and its valid level
//   clr_cmd_rdy     processor has taken cmd
//   overrun         sticky: a command completed while cmd was still unconsumed
//   timeout         one-cycle pulse: partial command discarded
//   send_resp/resp  one-cycle request to transmit resp
//   tx_done         transmitter finished the active byte
//   trmt/tx_data    transmitter start pulse and byte to send
//   tx_busy         a byte is in flight or pending
//   resp_drop       one-cycle pulse: response lost because the pending slot was full

module uart_cmd_sequencer #(
  parameter int TIMEOUT = 52080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        timeout,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        resp_drop
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } rx_state_t;

  rx_state_t       state;
  logic [7:0]      hi;
  logic [CW-1:0]   cnt;
  logic            pend_valid;
  logic [7:0]      pend_data;

  logic            cmd_complete;
  logic            cmd_accept;
  logic            tx_free;

  // Every state takes a byte the moment one is offered, so the consume strobe
  // is simply rx_rdy, held off while reset is abandoning work.
  assign clr_rx_rdy   = rx_rdy & ~rst;
  assign cmd_complete = (state == WAIT_LO) & rx_rdy;
  // A consume in the completion cycle frees the cmd register for the new command.
  assign cmd_accept   = ~cmd_rdy | clr_cmd_rdy;
  // Active slot is available if idle or being vacated this cycle.
  assign tx_free      = ~tx_busy | tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            hi    <= rx_data;
            cnt   <= CNT_LOAD;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // The byte is checked first so a byte arriving on expiry still counts.
          if (rx_rdy) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            timeout <= 1'b1;
            hi      <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase

      if (cmd_complete) begin
        if (cmd_accept) begin
          cmd     <= {hi, rx_data};
          cmd_rdy <= 1'b1;
          if (clr_cmd_rdy) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data    <= '0;
      trmt       <= 1'b0;
      tx_busy    <= 1'b0;
      resp_drop  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      trmt      <= 1'b0;
      resp_drop <= 1'b0;
      if (pend_valid) begin
        // Pending slot full: any new response is lost even if tx_done frees
        // the active slot, because the pending byte claims it.
        if (send_resp) resp_drop <= 1'b1;
        if (tx_done) begin
          tx_data    <= pend_data;
          trmt       <= 1'b1;
          pend_valid <= 1'b0;
        end
      end else if (tx_free) begin
        if (send_resp) begin
          tx_data <= resp;
          trmt    <= 1'b1;
          tx_busy <= 1'b1;
        end else if (tx_done) begin
          tx_busy <= 1'b0;
        end
      end else if (send_resp) begin
        pend_data  <= resp;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - self-checking bench for uart_cmd_sequencer

module tb_uart_cmd_sequencer;

  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy, overrun, timeout;
  logic        send_resp, tx_done, trmt, tx_busy, resp_drop;
  logic [7:0]  rx_data, resp, tx_data;
  logic [15:0] cmd;

  logic        tx_auto = 1'b0;
  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  assign tx_done = tx_auto ? auto_done : man_done;

  uart_cmd_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun),
    .timeout(timeout), .send_resp(send_resp), .resp(resp), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .tx_busy(tx_busy), .resp_drop(resp_drop)
  );

  // Transmitter stand-in: finishes each started byte 1..5 cycles after trmt.
  int tx_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    auto_done = 1'b0;
    if (trmt === 1'b1) tx_cnt = int'($urandom_range(1, 5));
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) auto_done = 1'b1;
    end
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model: timestamps for the inter-byte window, a byte queue for TX.
  bit          m_valid = 0;
  int          cyc = 0;
  bit          have_hi;
  logic [7:0]  hi_b;
  int          hi_t;
  logic [15:0] e_cmd;
  logic        e_rdy, e_ovr, e_to, e_trmt, e_drop;
  logic [7:0]  e_txd;
  logic [7:0]  txq[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit          got;
    logic [15:0] newc;
    int          sb;
    bit          dn;
    cyc++;
    if (rst) begin
      m_valid = 1; have_hi = 0; e_cmd = '0; e_rdy = 0; e_ovr = 0; e_to = 0;
      e_trmt = 0; e_txd = '0; e_drop = 0; txq.delete();
      return;
    end
    e_to = 0; e_trmt = 0; e_drop = 0;
    got = 0; newc = '0;
    if (rx_rdy) begin
      if (have_hi) begin
        got = 1; newc = {hi_b, rx_data}; have_hi = 0;
      end else begin
        have_hi = 1; hi_b = rx_data; hi_t = cyc;
      end
    end else if (have_hi && (cyc - hi_t) >= TIMEOUT) begin
      e_to = 1; have_hi = 0;
    end
    // Consume first, then deliver: a same-cycle consume makes room.
    if (clr_cmd_rdy) begin e_rdy = 0; e_ovr = 0; end
    if (got) begin
      if (e_rdy) e_ovr = 1;
      else begin e_cmd = newc; e_rdy = 1; end
    end
    sb = txq.size();
    dn = tx_done && sb > 0;
    if (dn) void'(txq.pop_front());
    if (send_resp) begin
      if (sb == 2) e_drop = 1;
      else txq.push_back(resp);
    end
    if (txq.size() > 0 && (dn || sb == 0)) begin
      e_trmt = 1; e_txd = txq[0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk1("clr_rx_rdy", clr_rx_rdy, rx_rdy && !rst);
    @(posedge clk);
    model_step();
    #2;
    if (m_valid) begin
      chk16("cmd", cmd, e_cmd);
      chk1("cmd_rdy", cmd_rdy, e_rdy);
      chk1("overrun", overrun, e_ovr);
      chk1("timeout", timeout, e_to);
      chk1("trmt", trmt, e_trmt);
      chk8("tx_data", tx_data, e_txd);
      chk1("tx_busy", tx_busy, txq.size() > 0);
      chk1("resp_drop", resp_drop, e_drop);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b; tick(); rx_rdy = 1'b0;
  endtask

  task automatic consume();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
  endtask

  task automatic respond(input logic [7:0] b);
    send_resp = 1'b1; resp = b; tick(); send_resp = 1'b0;
  endtask

  task automatic done_pulse();
    man_done = 1'b1; tick(); man_done = 1'b0;
  endtask

  int rx_p;

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = '0;
    tick(); tick();
    chk16("reset cmd", cmd, 16'h0000);
    chk1("reset cmd_rdy", cmd_rdy, 1'b0);
    chk1("reset tx_busy", tx_busy, 1'b0);
    rst = 1'b0;

    // Two bytes inside the window.
    rx_byte(8'hA5); idle_n(15); rx_byte(8'h3C);
    chk16("t1 cmd", cmd, 16'hA53C);
    chk1("t1 cmd_rdy", cmd_rdy, 1'b1);
    chk1("t1 timeout", timeout, 1'b0);
    consume();
    chk1("t1 cleared", cmd_rdy, 1'b0);
    chk16("t1 cmd held", cmd, 16'hA53C);

    // Lone high byte expires.
    rx_byte(8'h12); idle_n(19);
    chk1("t2 no early timeout", timeout, 1'b0);
    idle_n(1);
    chk1("t2 timeout pulse", timeout, 1'b1);
    idle_n(1);
    chk1("t2 timeout one cycle", timeout, 1'b0);
    rx_byte(8'h34); idle_n(3); rx_byte(8'h56);
    chk16("t2 cmd", cmd, 16'h3456);
    consume();

    // Low byte on the last allowed cycle.
    rx_byte(8'h77); idle_n(19); rx_byte(8'h88);
    chk16("t3 cmd", cmd, 16'h7788);
    chk1("t3 timeout", timeout, 1'b0);
    idle_n(1);
    chk1("t3 no late timeout", timeout, 1'b0);
    consume();

    // Overrun and consume-in-completion-cycle.
    rx_byte(8'h11); rx_byte(8'h11);
    rx_byte(8'h22); rx_byte(8'h22);
    chk16("t4 cmd kept", cmd, 16'h1111);
    chk1("t4 overrun", overrun, 1'b1);
    consume();
    chk1("t4 cmd_rdy clr", cmd_rdy, 1'b0);
    chk1("t4 overrun clr", overrun, 1'b0);
    rx_byte(8'h11); rx_byte(8'h11); rx_byte(8'h22);
    rx_rdy = 1'b1; rx_data = 8'h22; clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk16("t4 cmd replaced", cmd, 16'h2222);
    chk1("t4 cmd_rdy", cmd_rdy, 1'b1);
    chk1("t4 no overrun", overrun, 1'b0);
    consume();

    // Response path with pending slot and drop.
    respond(8'hA5);
    chk1("t5 trmt", trmt, 1'b1);
    chk8("t5 tx_data", tx_data, 8'hA5);
    chk1("t5 busy", tx_busy, 1'b1);
    respond(8'h5A);
    chk1("t5 no trmt", trmt, 1'b0);
    respond(8'hFF);
    chk1("t5 drop", resp_drop, 1'b1);
    chk8("t5 tx_data held", tx_data, 8'hA5);
    idle_n(1);
    chk1("t5 drop one cycle", resp_drop, 1'b0);
    done_pulse();
    chk1("t5 trmt pending", trmt, 1'b1);
    chk8("t5 tx_data pending", tx_data, 8'h5A);
    idle_n(1);
    chk1("t5 trmt single", trmt, 1'b0);
    done_pulse();
    chk1("t5 idle", tx_busy, 1'b0);

    // Reset mid-command with transmit pending.
    rx_byte(8'h99); rx_byte(8'h99);
    respond(8'hC3); respond(8'h3C);
    rx_byte(8'h44);
    rst = 1'b1; tick(); rst = 1'b0;
    chk16("t6 cmd", cmd, 16'h0000);
    chk1("t6 cmd_rdy", cmd_rdy, 1'b0);
    chk1("t6 trmt", trmt, 1'b0);
    chk8("t6 tx_data", tx_data, 8'h00);
    chk1("t6 tx_busy", tx_busy, 1'b0);
    rx_byte(8'h00); rx_byte(8'h01);
    chk16("t6 cmd after", cmd, 16'h0001);
    idle_n(25);
    consume();

    // Randomized traffic against the model.
    tx_auto = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0: rx_p = 2;
        1: rx_p = 6;
        2: rx_p = 30;
        default: rx_p = 70;
      endcase
      for (int i = 0; i < 500; i++) begin
        rx_rdy      = ($urandom_range(0, 99) < rx_p);
        rx_data     = 8'($urandom);
        clr_cmd_rdy = ($urandom_range(0, 99) < 20);
        send_resp   = ($urandom_range(0, 99) < 15);
        resp        = 8'($urandom);
        rst         = ($urandom_range(0, 999) == 0);
        tick();
      end
    end
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; rst = 1'b0;
    idle_n(10);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
